// File: rtl/seg_scan_ctrl_if.sv
// Display-value load handshake between a host and seg_scan_ctrl.
// A value transfers on a cycle where load_valid and load_ready are both high.
interface seg_scan_ctrl_if;
    logic        load_valid;
    logic [15:0] load_data;
    logic        load_ready;

    modport master (
        output load_valid,
        output load_data,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_data,
        output load_ready
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed BCD display scanner driving a shared hc4511 decoder.
// Every output is registered and computed from the next-state values, so outputs line up with the state register.
module seg_scan_ctrl #(
    parameter int SCAN_DIV  = 8,
    parameter int BLANK_CYC = 2,
    parameter int LT_CYC    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seg_scan_ctrl_if.slave       ld,
    input  logic                 lzb,
    input  logic                 lt_req,
    output logic [3:0]           A,
    output logic                 LE,
    output logic                 BI_N,
    output logic                 LT_N,
    output logic [3:0]           dig_en,
    output logic                 frame_done,
    output logic                 bcd_err
);

    typedef enum logic [2:0] {
        ST_RST   = 3'd0,
        ST_LT    = 3'd1,
        ST_BLANK = 3'd2,
        ST_LATCH = 3'd3,
        ST_SHOW  = 3'd4
    } state_t;

    localparam logic [7:0] LT_LAST    = 8'(LT_CYC - 1);
    localparam logic [7:0] BLANK_LAST = 8'(BLANK_CYC - 1);
    localparam logic [7:0] SHOW_LAST  = 8'(SCAN_DIV - 1);

    state_t      state_r, state_nx_s;
    logic [1:0]  d_r, d_nx_s;
    logic [7:0]  cnt_r, cnt_nx_s;
    logic [15:0] cur_r, cur_nx_s;
    logic [15:0] pend_r, pend_nx_s;
    logic        ready_r, ready_nx_s;
    logic        lt_pend_r, lt_pend_nx_s;
    logic        accept_s, boundary_s;

    logic [3:0]  a_r, a_nx_s;
    logic        le_r, le_nx_s;
    logic        bi_n_r, bi_n_nx_s;
    logic        lt_n_r, lt_n_nx_s;
    logic [3:0]  dig_r, dig_nx_s;
    logic        fd_r, fd_nx_s;
    logic        err_r, err_nx_s;

    function automatic logic [3:0] nibble(input logic [15:0] v, input logic [1:0] d);
        logic [3:0] n;
        case (d)
            2'd0:    n = v[3:0];
            2'd1:    n = v[7:4];
            2'd2:    n = v[11:8];
            2'd3:    n = v[15:12];
            default: n = 4'd0;
        endcase
        return n;
    endfunction

    // True when digit d and every more significant digit are zero; digit 0 is never suppressed.
    function automatic logic lead_zero(input logic [15:0] v, input logic [1:0] d);
        logic z;
        case (d)
            2'd1:    z = (v[15:4] == 12'd0);
            2'd2:    z = (v[15:8] == 8'd0);
            2'd3:    z = (v[15:12] == 4'd0);
            default: z = 1'b0;
        endcase
        return z;
    endfunction

    assign accept_s   = ld.load_valid && ready_r;
    assign boundary_s = ((state_r == ST_LT) && (cnt_r == LT_LAST)) ||
                        ((state_r == ST_SHOW) && (d_r == 2'd3) && (cnt_r == SHOW_LAST));
    assign ld.load_ready = ready_r;

    // Scan sequencing: next state, digit index and in-state cycle counter.
    always_comb begin
        state_nx_s = state_r;
        d_nx_s     = d_r;
        cnt_nx_s   = cnt_r + 8'd1;
        case (state_r)
            ST_RST: begin
                state_nx_s = ST_LT;
                d_nx_s     = 2'd0;
                cnt_nx_s   = 8'd0;
            end
            ST_LT: begin
                if (cnt_r == LT_LAST) begin
                    state_nx_s = ST_BLANK;
                    d_nx_s     = 2'd0;
                    cnt_nx_s   = 8'd0;
                end else begin
                    state_nx_s = ST_LT;
                end
            end
            ST_BLANK: begin
                if (cnt_r == BLANK_LAST) begin
                    state_nx_s = ST_LATCH;
                    cnt_nx_s   = 8'd0;
                end else begin
                    state_nx_s = ST_BLANK;
                end
            end
            ST_LATCH: begin
                state_nx_s = ST_SHOW;
                cnt_nx_s   = 8'd0;
            end
            ST_SHOW: begin
                if (cnt_r == SHOW_LAST) begin
                    cnt_nx_s = 8'd0;
                    if (d_r == 2'd3) begin
                        state_nx_s = lt_pend_r ? ST_LT : ST_BLANK;
                        d_nx_s     = 2'd0;
                    end else begin
                        state_nx_s = ST_BLANK;
                        d_nx_s     = d_r + 2'd1;
                    end
                end else begin
                    state_nx_s = ST_SHOW;
                end
            end
            default: begin
                state_nx_s = ST_LT;
                d_nx_s     = 2'd0;
                cnt_nx_s   = 8'd0;
            end
        endcase
    end

    // Shadow register handshake; a load taken on a boundary cycle waits for the next boundary.
    always_comb begin
        cur_nx_s   = cur_r;
        pend_nx_s  = pend_r;
        ready_nx_s = ready_r;
        if (accept_s) begin
            pend_nx_s  = ld.load_data;
            ready_nx_s = 1'b0;
        end else if (boundary_s && !ready_r) begin
            cur_nx_s   = pend_r;
            ready_nx_s = 1'b1;
        end else begin
            cur_nx_s   = cur_r;
        end
    end

    // Lamp-test request latch, cleared on entry and deaf while lamp test runs.
    always_comb begin
        lt_pend_nx_s = lt_pend_r;
        if (state_nx_s == ST_LT) begin
            lt_pend_nx_s = 1'b0;
        end else if (lt_req && (state_r != ST_LT) && (state_r != ST_RST)) begin
            lt_pend_nx_s = 1'b1;
        end else begin
            lt_pend_nx_s = lt_pend_r;
        end
    end

    // Decoder and digit drive for the state being entered.
    always_comb begin
        a_nx_s    = 4'd0;
        le_nx_s   = 1'b1;
        bi_n_nx_s = 1'b0;
        lt_n_nx_s = 1'b1;
        dig_nx_s  = 4'b0000;
        fd_nx_s   = 1'b0;
        err_nx_s  = 1'b0;
        case (state_nx_s)
            ST_LT: begin
                bi_n_nx_s = 1'b1;
                lt_n_nx_s = 1'b0;
                dig_nx_s  = 4'b1111;
            end
            ST_BLANK: begin
                a_nx_s = nibble(cur_nx_s, d_nx_s);
            end
            ST_LATCH: begin
                a_nx_s   = nibble(cur_nx_s, d_nx_s);
                le_nx_s  = 1'b0;
                err_nx_s = (nibble(cur_nx_s, d_nx_s) > 4'd9);
            end
            ST_SHOW: begin
                a_nx_s    = nibble(cur_nx_s, d_nx_s);
                bi_n_nx_s = !(lzb && lead_zero(cur_nx_s, d_nx_s));
                dig_nx_s  = 4'b0001 << d_nx_s;
                fd_nx_s   = (d_nx_s == 2'd3) && (cnt_nx_s == SHOW_LAST);
            end
            default: begin
                a_nx_s = 4'd0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_RST;
            d_r       <= 2'd0;
            cnt_r     <= 8'd0;
            cur_r     <= 16'd0;
            pend_r    <= 16'd0;
            ready_r   <= 1'b1;
            lt_pend_r <= 1'b0;
            a_r       <= 4'd0;
            le_r      <= 1'b1;
            bi_n_r    <= 1'b0;
            lt_n_r    <= 1'b1;
            dig_r     <= 4'b0000;
            fd_r      <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            d_r       <= d_nx_s;
            cnt_r     <= cnt_nx_s;
            cur_r     <= cur_nx_s;
            pend_r    <= pend_nx_s;
            ready_r   <= ready_nx_s;
            lt_pend_r <= lt_pend_nx_s;
            a_r       <= a_nx_s;
            le_r      <= le_nx_s;
            bi_n_r    <= bi_n_nx_s;
            lt_n_r    <= lt_n_nx_s;
            dig_r     <= dig_nx_s;
            fd_r      <= fd_nx_s;
            err_r     <= err_nx_s;
        end
    end

    assign A          = a_r;
    assign LE         = le_r;
    assign BI_N       = bi_n_r;
    assign LT_N       = lt_n_r;
    assign dig_en     = dig_r;
    assign frame_done = fd_r;
    assign bcd_err    = err_r;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with default parameters (8 show, 2 blank, 16 lamp-test cycles).
module tb_seg_scan_ctrl;

    logic       clk;
    logic       rst_n;
    logic       lzb;
    logic       lt_req;
    logic [3:0] A;
    logic       LE;
    logic       BI_N;
    logic       LT_N;
    logic [3:0] dig_en;
    logic       frame_done;
    logic       bcd_err;

    int n_cmp = 0;
    int n_err = 0;

    seg_scan_ctrl_if ld_if ();

    seg_scan_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ld         (ld_if),
        .lzb        (lzb),
        .lt_req     (lt_req),
        .A          (A),
        .LE         (LE),
        .BI_N       (BI_N),
        .LT_N       (LT_N),
        .dig_en     (dig_en),
        .frame_done (frame_done),
        .bcd_err    (bcd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] bus();
        return {5'd0, A, LE, BI_N, LT_N, dig_en};
    endfunction

    function automatic logic [15:0] eb(input logic [3:0] a, input logic le, input logic bi,
                                       input logic lt, input logic [3:0] dig);
        return {5'd0, a, le, bi, lt, dig};
    endfunction

    // One-shot inputs drop after every edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            ld_if.load_valid = 1'b0;
            lt_req           = 1'b0;
        end
    endtask

    // Entered on the first BLANK cycle of a digit; leaves on its last SHOW cycle.
    task automatic check_digit(input string tag, input logic [3:0] a, input logic bi,
                               input logic [3:0] dig, input logic last);
        chk({tag, "_blank1"}, bus(), eb(a, 1'b1, 1'b0, 1'b1, 4'b0000));
        step(1);
        chk({tag, "_blank2"}, bus(), eb(a, 1'b1, 1'b0, 1'b1, 4'b0000));
        step(1);
        chk({tag, "_latch"}, bus(), eb(a, 1'b0, 1'b0, 1'b1, 4'b0000));
        chk({tag, "_err_latch"}, {15'd0, bcd_err}, {15'd0, (a > 4'd9)});
        step(1);
        chk({tag, "_show1"}, bus(), eb(a, 1'b1, bi, 1'b1, dig));
        chk({tag, "_err_show"}, {15'd0, bcd_err}, 16'd0);
        step(7);
        chk({tag, "_show8"}, bus(), eb(a, 1'b1, bi, 1'b1, dig));
        chk({tag, "_fdone"}, {15'd0, frame_done}, {15'd0, last});
    endtask

    task automatic check_frame(input string tag, input logic [15:0] val, input logic [3:0] bi);
        for (int d = 0; d < 4; d++) begin
            check_digit($sformatf("%s_d%0d", tag, d), val[4*d +: 4], bi[d],
                        4'b0001 << d, (d == 3));
            if (d < 3) step(1);
        end
    endtask

    function automatic logic [15:0] lt_bus();
        return eb(4'd0, 1'b1, 1'b1, 1'b0, 4'b1111);
    endfunction

    function automatic logic [15:0] rst_bus();
        return eb(4'd0, 1'b1, 1'b0, 1'b1, 4'b0000);
    endfunction

    initial begin
        rst_n            = 1'b0;
        lzb              = 1'b0;
        lt_req           = 1'b0;
        ld_if.load_valid = 1'b0;
        ld_if.load_data  = 16'h0000;
        step(3);
        chk("rst_bus", bus(), rst_bus());
        chk("rst_ready", {15'd0, ld_if.load_ready}, 16'd1);
        chk("rst_fdone", {15'd0, frame_done}, 16'd0);
        chk("rst_err", {15'd0, bcd_err}, 16'd0);

        // Lamp test after release, load 1953 while it runs.
        rst_n = 1'b1;
        step(1);
        chk("lt1_bus", bus(), lt_bus());
        chk("lt1_ready", {15'd0, ld_if.load_ready}, 16'd1);
        ld_if.load_valid = 1'b1;
        ld_if.load_data  = 16'h1953;
        step(1);
        chk("lt2_bus", bus(), lt_bus());
        chk("lt2_ready", {15'd0, ld_if.load_ready}, 16'd0);
        step(14);
        chk("lt16_bus", bus(), lt_bus());
        chk("lt16_ready", {15'd0, ld_if.load_ready}, 16'd0);
        step(1);
        chk("fa_ready", {15'd0, ld_if.load_ready}, 16'd1);
        check_frame("fa", 16'h1953, 4'b1111);

        // Load on the frame_done cycle waits a whole frame.
        ld_if.load_valid = 1'b1;
        ld_if.load_data  = 16'h1234;
        step(1);
        chk("fb_ready", {15'd0, ld_if.load_ready}, 16'd0);
        check_frame("fb", 16'h1953, 4'b1111);
        step(1);
        chk("fc_ready", {15'd0, ld_if.load_ready}, 16'd1);
        ld_if.load_valid = 1'b1;
        ld_if.load_data  = 16'h0042;
        lzb              = 1'b1;
        check_frame("fc", 16'h1234, 4'b1111);

        // Leading-zero blanking on and off.
        step(1);
        check_frame("fd", 16'h0042, 4'b0011);
        lzb = 1'b0;
        step(1);
        ld_if.load_valid = 1'b1;
        ld_if.load_data  = 16'h0000;
        check_frame("fe", 16'h0042, 4'b1111);
        lzb = 1'b1;
        step(1);
        ld_if.load_valid = 1'b1;
        ld_if.load_data  = 16'h00E7;
        check_frame("ff", 16'h0000, 4'b0001);

        // Invalid nibble plus a mid-frame lamp-test request.
        step(1);
        lt_req = 1'b1;
        check_frame("fg", 16'h00E7, 4'b0011);
        step(1);
        chk("lt_b1", bus(), lt_bus());
        lt_req = 1'b1;
        step(1);
        chk("lt_b2", bus(), lt_bus());
        step(13);
        chk("lt_b15", bus(), lt_bus());
        step(1);
        chk("lt_b16", bus(), lt_bus());
        step(1);
        check_frame("fh", 16'h00E7, 4'b0011);
        step(1);
        chk("fi_no_lt", bus(), eb(4'd7, 1'b1, 1'b0, 1'b1, 4'b0000));

        // Reset in SHOW of digit 2 discards the pending value.
        ld_if.load_valid = 1'b1;
        ld_if.load_data  = 16'h5555;
        step(25);
        chk("fi_show_d2", bus(), eb(4'd0, 1'b1, 1'b0, 1'b1, 4'b0100));
        chk("fi_ready", {15'd0, ld_if.load_ready}, 16'd0);
        rst_n = 1'b0;
        step(1);
        chk("rst2_bus", bus(), rst_bus());
        chk("rst2_ready", {15'd0, ld_if.load_ready}, 16'd1);
        chk("rst2_fdone", {15'd0, frame_done}, 16'd0);
        chk("rst2_err", {15'd0, bcd_err}, 16'd0);
        rst_n = 1'b1;
        step(1);
        chk("lt_c1", bus(), lt_bus());
        step(15);
        chk("lt_c16", bus(), lt_bus());
        step(1);
        chk("fj_blank_cur0", bus(), eb(4'd0, 1'b1, 1'b0, 1'b1, 4'b0000));
        chk("fj_ready", {15'd0, ld_if.load_ready}, 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 8: cycles each digit is lit (SHOW), range 1..255.
REQ-002 Parameter BLANK_CYC, default 2: blanking cycles before each digit (BLANK), range 1..15.
REQ-003 Parameter LT_CYC, default 16: lamp-test duration in cycles, range 1..255.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-006 load_valid  input  1  new display value offered.
REQ-007 load_data  input  16  four BCD nibbles; [3:0] is digit 0 (least significant).
REQ-008 load_ready  output  1  shadow register free; transfer on load_valid && load_ready.
REQ-009 lzb  input  1  leading-zero blanking enable, level-sensitive.
REQ-010 lt_req  input  1  request one lamp-test interval at next frame boundary.
REQ-011 A  output  4  BCD code to shared hc4511 decoder.
REQ-012 LE  output  1  hc4511 latch enable; 0 = transparent, 1 = hold.
REQ-013 BI_N  output  1  hc4511 blanking, active-low.
REQ-014 LT_N  output  1  hc4511 lamp test, active-low.
REQ-015 dig_en  output  4  one-hot digit common drive; bit n = digit n.
REQ-016 frame_done  output  1  one-cycle pulse on last SHOW cycle of digit 3.
REQ-017 bcd_err  output  1  one-cycle pulse when a nibble >9 is latched.

Function
REQ-018 States: LAMP_TEST, BLANK, LATCH, SHOW; digit index d in 0..3, scan order 0,1,2,3,0.
REQ-019 LAMP_TEST: LT_N=0, BI_N=1, LE=1, dig_en=4'b1111 for exactly LT_CYC cycles, then BLANK with d=0.
REQ-020 BLANK: dig_en=0, BI_N=0, LE=1, LT_N=1, A=cur[4d+3:4d]; lasts BLANK_CYC cycles, then LATCH.
REQ-021 LATCH: exactly 1 cycle; LE=0, A=cur[4d+3:4d], dig_en=0, BI_N=0; then SHOW.
REQ-022 SHOW: LE=1, dig_en=one-hot(d), LT_N=1, A held; SCAN_DIV cycles, then BLANK with d+1 (wrap 3->0).
REQ-023 SHOW BI_N=1, except BI_N=0 when lzb=1, d>0 and nibble d and all higher nibbles are 0; digit 0 never suppressed.
REQ-024 Digit period = BLANK_CYC+1+SCAN_DIV; frame = 4x that (44 cycles with defaults); dig_en never has >1 bit set outside LAMP_TEST.
REQ-025 Load accept: pending <= load_data, load_ready falls next cycle; cur unchanged until frame boundary.
REQ-026 Frame boundary = cycle frame_done=1, or last LAMP_TEST cycle: if pending full, cur <= pending, load_ready rises next cycle.
REQ-027 Load accepted on a frame-boundary cycle is NOT bypassed to cur; applied at the following boundary.
REQ-028 lt_req=1 sets sticky lt_pend; at frame boundary with lt_pend=1 next state is LAMP_TEST (not BLANK d=0), lt_pend cleared on entry.
REQ-029 lt_req asserted while in LAMP_TEST is ignored.
REQ-030 bcd_err pulses in the LATCH cycle whose nibble is 10..15; A passes the value unchanged (decoder blanks it).
REQ-031 Internal counters sized to parameter maxima; no counter wraps within a state.

Reset
REQ-032 While rst_n=0: A=0, LE=1, BI_N=0, LT_N=1, dig_en=0, load_ready=1, frame_done=0, bcd_err=0, cur=0, pending empty, lt_pend=0.
REQ-033 First cycle after rst_n rises: state LAMP_TEST, LT_CYC-cycle count starts.
REQ-034 rst_n low mid-frame or mid-lamp-test aborts immediately; pending value discarded.

Verification
REQ-035 Reset release, defaults -> LT_N=0, dig_en=1111 for 16 cycles; then BLANK 2 cycles (dig_en=0, BI_N=0), LATCH 1 cycle LE=0 A=0, SHOW 8 cycles dig_en=0001.
REQ-036 Load 16'h1953 during LAMP_TEST -> load_ready=0 next cycle; first frame shows A=3,5,9,1 with dig_en 0001,0010,0100,1000; load_ready=1 after LAMP_TEST ends.
REQ-037 cur=16'h0042, lzb=1 -> SHOW d=2,3 with BI_N=0; d=0,1 BI_N=1; lzb=0 -> all four BI_N=1; cur=0, lzb=1 -> digit 0 shows 0.
REQ-038 Load 16'h1234 on frame_done cycle -> next frame still shows old value; frame after shows 4,3,2,1.
REQ-039 lt_req pulsed mid-frame -> frame completes, frame_done pulses, then 16-cycle LAMP_TEST, then d=0; second lt_req during lamp test has no effect.
REQ-040 Load 16'h00E7 -> bcd_err pulses in LATCH of d=1 only; rst_n low during SHOW d=2 -> next cycle all outputs at REQ-032 values.
